eem16_proj2: RTL and testbench



---
 rtl/eem16_proj2_pkg.sv | 29 ++
 rtl/eem16_proj2_seg7_rom.sv | 41 ++++
 rtl/eem16_proj2.sv | 49 ++++
 tb/tb_eem16_proj2.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/eem16_proj2_pkg.sv
// eem16_proj2_pkg
// Shared definitions for the registered BCD-to-seven-segment decoder.
// - seg_t: 7-bit abcdefg segment vector, bit 6 = a ... bit 0 = g, 1 = lit.
// - SEG_0..SEG_9: decimal glyphs.
// - SEG_A..SEG_F: hex glyphs, only used when EEM16_PROJ2_HEX_EN is defined.
// - SEG_BLANK: all segments off.
package eem16_proj2_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;  // six drawn with top tail
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;  // nine drawn with bottom tail
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b0011111;  // lower-case b
    localparam seg_t SEG_C     = 7'b1001110;
    localparam seg_t SEG_D     = 7'b0111101;  // lower-case d
    localparam seg_t SEG_E     = 7'b1001111;
    localparam seg_t SEG_F     = 7'b1000111;
    localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/eem16_proj2_seg7_rom.sv
// seg7_rom
// Combinational 4-bit code to abcdefg pattern lookup.
// Ports:
//   code    in  4  digit code 0..15
//   pattern out 7  abcdefg pattern (bit 6 = a)
// Configuration macro: EEM16_PROJ2_HEX_EN
//   defined   -> codes 10..15 show hex glyphs A b C d E F
//   undefined -> codes 10..15 are blanked
module seg7_rom
    import eem16_proj2_pkg::*;
(
    input  logic [3:0] code,
    output seg_t       pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (code)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
`ifdef EEM16_PROJ2_HEX_EN
            4'd10:   pattern = SEG_A;
            4'd11:   pattern = SEG_B;
            4'd12:   pattern = SEG_C;
            4'd13:   pattern = SEG_D;
            4'd14:   pattern = SEG_E;
            4'd15:   pattern = SEG_F;
`endif
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/eem16_proj2.sv
// eem16_proj2
// Registered BCD-to-seven-segment decoder for one display digit. The digit
// {x3,x2,x1,x0} is sampled every rising edge and its pattern appears on a..g
// right after that edge (1-cycle latency). All outputs come straight from
// flip-flops so input glitches between edges never reach the pins.
// Ports:
//   clk      in  1  rising-edge clock
//   rst_n    in  1  asynchronous active-low reset, blanks a..g at once
//   x3..x0   in  1  BCD digit, x3 = MSB
//   a..g     out 1  active-high segment drives (a top ... g middle)
// Configuration macro: EEM16_PROJ2_HEX_EN (hex glyphs for codes 10..15,
// handled inside seg7_rom; default build blanks them).
module eem16_proj2
    import eem16_proj2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic x3,
    input  logic x2,
    input  logic x1,
    input  logic x0,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g
);

    seg_t seg_next;
    seg_t seg_reg;

    seg7_rom u_rom (
        .code    ({x3, x2, x1, x0}),
        .pattern (seg_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg <= SEG_BLANK;
        end else begin
            seg_reg <= seg_next;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_reg;

endmodule

// File: tb/tb_eem16_proj2.sv
// tb_eem16_proj2
// Scoreboard bench for eem16_proj2: each driven code pushes its expected
// abcdefg pattern; the pattern is popped and compared one edge later.
// Honours EEM16_PROJ2_HEX_EN the same way as the design build.
module tb_eem16_proj2;

    logic clk;
    logic rst_n;
    logic x3, x2, x1, x0;
    logic a, b, c, d, e, f, g;

    int n_compared;
    int n_mismatch;
    logic [6:0] exp_q[$];

    eem16_proj2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x3    (x3),
        .x2    (x2),
        .x1    (x1),
        .x0    (x0),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .e     (e),
        .f     (f),
        .g     (g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] seg_out();
        return {a, b, c, d, e, f, g};
    endfunction

    // Reference glyph table written out independently of the RTL package.
    function automatic logic [6:0] model(input int code);
        case (code)
            0:  return 7'b1111110;
            1:  return 7'b0110000;
            2:  return 7'b1101101;
            3:  return 7'b1111001;
            4:  return 7'b0110011;
            5:  return 7'b1011011;
            6:  return 7'b1011111;
            7:  return 7'b1110000;
            8:  return 7'b1111111;
            9:  return 7'b1111011;
`ifdef EEM16_PROJ2_HEX_EN
            10: return 7'b1110111;
            11: return 7'b0011111;
            12: return 7'b1001110;
            13: return 7'b0111101;
            14: return 7'b1001111;
            15: return 7'b1000111;
`endif
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        n_compared++;
        if (obs !== exp_v) begin
            n_mismatch++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp_v, $time);
        end else begin
            $display("ok   %s: %b at %0t", tag, obs, $time);
        end
    endtask

    task automatic set_code(input int code);
        logic [3:0] v;
        v = code[3:0];
        {x3, x2, x1, x0} = v;
    endtask

    // Drive a code at the falling edge, push its expectation, then compare
    // just after the next rising edge. With glitch set, the inputs are
    // wiggled between edges and the held output is re-checked.
    task automatic step(input int code, input string tag, input bit glitch);
        logic [6:0] exp_v;
        @(negedge clk);
        set_code(code);
        exp_q.push_back(model(code));
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        check($sformatf("%s code=%0d", tag, code), seg_out(), exp_v);
        if (glitch) begin
            set_code($urandom_range(0, 15));
            #1;
            set_code($urandom_range(0, 15));
            #1;
            check($sformatf("%s hold code=%0d", tag, code), seg_out(), exp_v);
        end
    endtask

    initial begin
        n_compared = 0;
        n_mismatch = 0;

        // Reset held with code 8 present; outputs blank before any edge.
        rst_n = 1'b0;
        set_code(8);
        #2;
        check("reset_no_clock", seg_out(), 7'b0000000);
        @(posedge clk);
        #1;
        check("reset_held_edge", seg_out(), 7'b0000000);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(model(8));
        @(posedge clk);
        #1;
        check("reset_release code=8", seg_out(), exp_q.pop_front());

        // Decimal sweep.
        for (int i = 0; i <= 9; i++) step(i, "sweep", 1'b0);

        // Invalid codes: blank or hex depending on build.
        for (int i = 10; i <= 15; i++) step(i, "invalid", 1'b0);

        // Async reset while 9 is displayed.
        step(9, "pre_reset", 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_between_edges", seg_out(), 7'b0000000);
        @(posedge clk);
        #1;
        check("async_reset_held", seg_out(), 7'b0000000);

        // Code in flight when reset hits is discarded.
        @(negedge clk);
        rst_n = 1'b1;
        set_code(3);
        exp_q.push_back(model(3));
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("inflight_discard", seg_out(), 7'b0000000);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back 1/8 alternation with glitching inputs between edges.
        for (int i = 0; i < 8; i++) step((i % 2 == 0) ? 1 : 8, "alt", 1'b1);

        // Random codes.
        for (int i = 0; i < 16; i++) step($urandom_range(0, 15), "rand", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
